nco_phase_acc: RTL and testbench

Numerically controlled phase generator that drives the sine lookup stage. Each sample tick it adds a programmable frequency word to an AW-bit accumulator. It presents the top PW bits as the phase, with a clock-enable strobe and a wrap flag, directly on the lookup's `i_ce` / `i_phase` / `i_aux` inputs. Frequency and phase-sync changes are double-buffered so they take effect only on a sample tick.

---
 rtl/nco_pkg.sv | 8 +
 rtl/nco_ce_gen.sv | 33 +++
 rtl/nco_phase_acc.sv | 105 ++++++++++
 tb/tb_nco_phase_acc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared widths for the NCO phase generator and sine lookup
package nco_pkg;

    localparam int NCO_AW = 32;
    localparam int NCO_PW = 17;
    localparam int NCO_DW = 16;

endpackage

// File: rtl/nco_ce_gen.sv
// rtl/nco_ce_gen.sv - down-counting sample-rate divider, one tick every i_rate+1 clocks
module nco_ce_gen
    import nco_pkg::*;
#(
    parameter int DW = NCO_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] i_rate,
    output logic          o_tick
);

    logic [DW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == '0);

    // i_rate is only looked at on reload, so a change never shortens the running interval
    always_comb begin
        cnt_d = cnt_q - DW'(1);
        if (o_tick) begin
            cnt_d = i_rate;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nco_phase_acc.sv
// rtl/nco_phase_acc.sv - phase accumulator with double-buffered frequency and sync
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int AW = NCO_AW,
    parameter int PW = NCO_PW,
    parameter int DW = NCO_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ld,
    input  logic [AW-1:0] i_incr,
    input  logic          i_sync,
    input  logic [DW-1:0] i_rate,
    output logic          o_ce,
    output logic [PW-1:0] o_phase,
    output logic          o_aux
);

    logic          tick;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] incr_q, incr_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          sync_p_q, sync_p_d;
    logic          ce_q, ce_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          aux_q, aux_d;
    logic [AW-1:0] incr_eff;
    logic [AW:0]   sum;

    nco_ce_gen #(.DW(DW)) u_ce_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_rate  (i_rate),
        .o_tick  (tick)
    );

    assign incr_eff = pend_v_q ? pend_q : incr_q;
    assign sum      = {1'b0, acc_q} + {1'b0, incr_eff};

    always_comb begin
        acc_d    = acc_q;
        incr_d   = incr_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        sync_p_d = sync_p_q;
        ce_d     = tick;
        phase_d  = phase_q;
        aux_d    = aux_q;

        if (tick) begin
            if (pend_v_q) begin
                incr_d   = pend_q;
                pend_v_d = 1'b0;
            end
            if (sync_p_q) begin
                acc_d    = '0;
                phase_d  = '0;
                aux_d    = 1'b0;
                sync_p_d = 1'b0;
            end else begin
                acc_d    = sum[AW-1:0];
                phase_d  = sum[AW-1 -: PW];
                aux_d    = sum[AW];
            end
        end

        // New requests arriving on a tick are kept for the following tick
        if (i_ld) begin
            pend_d   = i_incr;
            pend_v_d = 1'b1;
        end
        if (i_sync) begin
            sync_p_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q    <= '0;
            incr_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            sync_p_q <= 1'b0;
            ce_q     <= 1'b0;
            phase_q  <= '0;
            aux_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            incr_q   <= incr_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            sync_p_q <= sync_p_d;
            ce_q     <= ce_d;
            phase_q  <= phase_d;
            aux_q    <= aux_d;
        end
    end

    assign o_ce    = ce_q;
    assign o_phase = phase_q;
    assign o_aux   = aux_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// tb/tb_nco_phase_acc.sv - directed-vector bench for nco_phase_acc
module tb_nco_phase_acc;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ld = 1'b0;
    logic [31:0] i_incr = '0;
    logic        i_sync = 1'b0;
    logic [15:0] i_rate = '0;
    logic        o_ce;
    logic [16:0] o_phase;
    logic        o_aux;

    int n_vec = 0;
    int n_err = 0;
    int n;

    nco_phase_acc dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ld    (i_ld),
        .i_incr  (i_incr),
        .i_sync  (i_sync),
        .i_rate  (i_rate),
        .o_ce    (o_ce),
        .o_phase (o_phase),
        .o_aux   (o_aux)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ce(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!o_ce && cnt < 64);
        if (!o_ce) cnt = 99;
    endtask

    task automatic do_reset(input logic [15:0] rate);
        i_reset = 1'b1;
        i_rate  = rate;
        i_ld    = 1'b0;
        i_sync  = 1'b0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        // reset and first tick
        i_rate = 16'd3;
        repeat (3) step();
        chk("rst_ce", {31'b0, o_ce}, 32'd0);
        chk("rst_phase", {15'b0, o_phase}, 32'd0);
        chk("rst_aux", {31'b0, o_aux}, 32'd0);
        i_reset = 1'b0;
        step();
        chk("first_ce", {31'b0, o_ce}, 32'd1);
        wait_ce(n);
        chk("rate3_int1", n, 32'd4);
        chk("rate3_phase", {15'b0, o_phase}, 32'd0);
        wait_ce(n);
        chk("rate3_int2", n, 32'd4);
        chk("rate3_aux", {31'b0, o_aux}, 32'd0);

        // stepping and wrap
        do_reset(16'd0);
        i_ld = 1'b1;
        i_incr = 32'h1000_0000;
        step();
        i_ld = 1'b0;
        chk("step_ce0", {31'b0, o_ce}, 32'd1);
        chk("step_ph0", {15'b0, o_phase}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("step_ce", {31'b0, o_ce}, 32'd1);
            chk("step_phase", {15'b0, o_phase}, (k * 32'h2000) & 32'h1FFFF);
            chk("step_aux", {31'b0, o_aux}, (k == 16) ? 32'd1 : 32'd0);
        end

        // double-buffered frequency
        do_reset(16'd7);
        i_ld = 1'b1;
        i_incr = 32'h0100_0000;
        step();
        i_ld = 1'b0;
        chk("db_ph0", {15'b0, o_phase}, 32'd0);
        wait_ce(n);
        chk("db_int", n, 32'd8);
        chk("db_ph1", {15'b0, o_phase}, 32'h200);
        step();
        step();
        i_ld = 1'b1;
        i_incr = 32'h0200_0000;
        step();
        i_ld = 1'b0;
        step();
        i_ld = 1'b1;
        i_incr = 32'h0400_0000;
        step();
        i_ld = 1'b0;
        wait_ce(n);
        chk("db_int2", n, 32'd3);
        chk("db_ph2", {15'b0, o_phase}, 32'hA00);
        wait_ce(n);
        chk("db_ph3", {15'b0, o_phase}, 32'h1200);

        // ld and sync coincident with a tick
        repeat (7) step();
        i_ld = 1'b1;
        i_incr = 32'h0080_0000;
        i_sync = 1'b1;
        step();
        i_ld = 1'b0;
        i_sync = 1'b0;
        chk("co_ce", {31'b0, o_ce}, 32'd1);
        chk("co_ph", {15'b0, o_phase}, 32'h1A00);
        chk("co_aux", {31'b0, o_aux}, 32'd0);
        wait_ce(n);
        chk("co_int", n, 32'd8);
        chk("co_sync_ph", {15'b0, o_phase}, 32'd0);
        chk("co_sync_aux", {31'b0, o_aux}, 32'd0);
        wait_ce(n);
        chk("co_new_ph", {15'b0, o_phase}, 32'h100);

        // reset mid-run on a tick with a pending word
        i_ld = 1'b1;
        i_incr = 32'h2000_0000;
        step();
        i_ld = 1'b0;
        repeat (6) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("mr_ce", {31'b0, o_ce}, 32'd0);
        chk("mr_ph", {15'b0, o_phase}, 32'd0);
        chk("mr_aux", {31'b0, o_aux}, 32'd0);
        step();
        chk("mr_ce1", {31'b0, o_ce}, 32'd1);
        chk("mr_ph1", {15'b0, o_phase}, 32'd0);
        wait_ce(n);
        chk("mr_int", n, 32'd8);
        chk("mr_ph2", {15'b0, o_phase}, 32'd0);

        // divider rate change mid-interval
        do_reset(16'd2);
        step();
        chk("rc_ce", {31'b0, o_ce}, 32'd1);
        wait_ce(n);
        chk("rc_int2", n, 32'd3);
        step();
        i_rate = 16'd5;
        wait_ce(n);
        chk("rc_cur", n + 1, 32'd3);
        wait_ce(n);
        chk("rc_int6a", n, 32'd6);
        wait_ce(n);
        chk("rc_int6b", n, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
